// File: rtl/regfile_pkg.sv
// Shared parameters and types for the multi-port register file and its
// per-register pending-write counters.
package regfile_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int PEND_W     = 2;
    localparam int PEND_MAX   = 3;

    typedef logic [PEND_W-1:0] pend_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback logic (master) and regfile_mp (slave).
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    // No valid/ready handshake: every input is a single-edge qualifier,
    // sampled once on each falling edge of clk; outputs are level signals.
    logic [ADDR_W-1:0]                 rd_addr0, rd_addr1;
    logic [DATA_W-1:0]                 rd_data0, rd_data1;
    logic                              rd_busy0, rd_busy1;
    logic                              wr_en0, wr_en1;
    logic [ADDR_W-1:0]                 wr_addr0, wr_addr1;
    logic [DATA_W-1:0]                 wr_data0, wr_data1;
    logic                              wr_rel0, wr_rel1;
    logic                              rsv_en;
    logic [ADDR_W-1:0]                 rsv_addr;
    logic                              err;
    logic [(2**ADDR_W)*PEND_W-1:0]     pend_dbg;

    modport master (
        output rd_addr0, rd_addr1, wr_en0, wr_en1, wr_addr0, wr_addr1,
               wr_data0, wr_data1, wr_rel0, wr_rel1, rsv_en, rsv_addr,
        input  rd_data0, rd_data1, rd_busy0, rd_busy1, err, pend_dbg
    );

    modport slave (
        input  rd_addr0, rd_addr1, wr_en0, wr_en1, wr_addr0, wr_addr1,
               wr_data0, wr_data1, wr_rel0, wr_rel1, rsv_en, rsv_addr,
        output rd_data0, rd_data1, rd_busy0, rd_busy1, err, pend_dbg
    );
endinterface

// File: rtl/pend_ctr.sv
// 2-bit saturating up/down counter of in-flight writes for one register;
// err_o pulses whenever the requested update would leave the 0..PEND_MAX range.
module pend_ctr import regfile_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic [1:0] dec_i,
    output pend_t      count_o,
    output logic       err_o
);
    pend_t             count_q, count_d;
    logic [PEND_W:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + {{PEND_W{1'b0}}, inc_i};
        count_d = count_q;
        err_o   = 1'b0;
        if ({1'b0, dec_i} > sum) begin
            count_d = '0;
            err_o   = 1'b1;
        end else if ((sum - {1'b0, dec_i}) > (PEND_W+1)'(PEND_MAX)) begin
            count_d = pend_t'(PEND_MAX);
            err_o   = 1'b1;
        end else begin
            count_d = pend_t'(sum - {1'b0, dec_i});
        end
    end

    always_ff @(negedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/regfile_mp.sv
// Dual-write, dual-read register file with optional write-to-read bypass and
// per-register pending-write counters for RAW stall detection. Falling-edge state.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    pend_t             pend [DEPTH];
    logic [DEPTH-1:0]  err_pulse;
    logic              err_q, err_d;

    // Port 1 is the later pipeline stage, so its write is applied last and wins.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            if (bus.wr_en0) regs_q[bus.wr_addr0] <= bus.wr_data0;
            if (bus.wr_en1) regs_q[bus.wr_addr1] <= bus.wr_data1;
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_pend
        logic       inc, hit0, hit1;
        logic [1:0] dec;

        assign inc  = bus.rsv_en && (bus.rsv_addr == ADDR_W'(r));
        assign hit0 = bus.wr_en0 && bus.wr_rel0 && (bus.wr_addr0 == ADDR_W'(r));
        assign hit1 = bus.wr_en1 && bus.wr_rel1 && (bus.wr_addr1 == ADDR_W'(r));
        assign dec  = {1'b0, hit0} + {1'b0, hit1};

        pend_ctr u_pend_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (inc),
            .dec_i   (dec),
            .count_o (pend[r]),
            .err_o   (err_pulse[r])
        );

        assign bus.pend_dbg[r*PEND_W +: PEND_W] = pend[r];
    end

    assign err_d = err_q | (|err_pulse);

    always_ff @(negedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    always_comb begin
        bus.rd_data0 = regs_q[bus.rd_addr0];
        bus.rd_data1 = regs_q[bus.rd_addr1];
        if (BYPASS != 0) begin
            if (bus.wr_en0 && (bus.wr_addr0 == bus.rd_addr0)) bus.rd_data0 = bus.wr_data0;
            if (bus.wr_en1 && (bus.wr_addr1 == bus.rd_addr0)) bus.rd_data0 = bus.wr_data1;
            if (bus.wr_en0 && (bus.wr_addr0 == bus.rd_addr1)) bus.rd_data1 = bus.wr_data0;
            if (bus.wr_en1 && (bus.wr_addr1 == bus.rd_addr1)) bus.rd_data1 = bus.wr_data1;
        end
    end

    // Busy reflects registered state only; it is never bypassed.
    assign bus.rd_busy0 = (pend[bus.rd_addr0] != '0);
    assign bus.rd_busy1 = (pend[bus.rd_addr1] != '0);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: drives a BYPASS=0 and a BYPASS=1 instance in
// lockstep; expectations are queued by the driver and checked at each rising edge.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_BSY0 = 2;
    localparam int K_BSY1 = 3;
    localparam int K_ERR  = 4;
    localparam int K_PEND = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus1.rd_addr0 = bus0.rd_addr0;
    assign bus1.rd_addr1 = bus0.rd_addr1;
    assign bus1.wr_en0   = bus0.wr_en0;
    assign bus1.wr_en1   = bus0.wr_en1;
    assign bus1.wr_addr0 = bus0.wr_addr0;
    assign bus1.wr_addr1 = bus0.wr_addr1;
    assign bus1.wr_data0 = bus0.wr_data0;
    assign bus1.wr_data1 = bus0.wr_data1;
    assign bus1.wr_rel0  = bus0.wr_rel0;
    assign bus1.wr_rel1  = bus0.wr_rel1;
    assign bus1.rsv_en   = bus0.rsv_en;
    assign bus1.rsv_addr = bus0.rsv_addr;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int            kind;
        int            sel;
        int            idx;
        logic [DW-1:0] val;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [DW-1:0] actual(int kind, int sel, int idx);
        logic [DW-1:0] v;
        v = '0;
        case (kind)
            K_RD0:  v = (sel != 0) ? bus1.rd_data0 : bus0.rd_data0;
            K_RD1:  v = (sel != 0) ? bus1.rd_data1 : bus0.rd_data1;
            K_BSY0: v = DW'((sel != 0) ? bus1.rd_busy0 : bus0.rd_busy0);
            K_BSY1: v = DW'((sel != 0) ? bus1.rd_busy1 : bus0.rd_busy1);
            K_ERR:  v = DW'((sel != 0) ? bus1.err : bus0.err);
            K_PEND: v = DW'((sel != 0) ? bus1.pend_dbg[idx*PEND_W +: PEND_W]
                                       : bus0.pend_dbg[idx*PEND_W +: PEND_W]);
            default: v = 'x;
        endcase
        return v;
    endfunction

    // Monitor: outputs are stable mid-cycle, away from the falling update edge.
    always @(posedge clk) begin
        exp_t          e;
        logic [DW-1:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual(e.kind, e.sel, e.idx);
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got %h, expected %h", e.name, e.sel, act, e.val);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(int kind, int sel, int idx, logic [DW-1:0] v, string name);
        exp_t e;
        e.kind = kind;
        e.sel  = sel;
        e.idx  = idx;
        e.val  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic both(int kind, int idx, logic [DW-1:0] v, string name);
        push(kind, 0, idx, v, name);
        push(kind, 1, idx, v, name);
    endtask

    task automatic clear_inputs();
        bus0.wr_en0   = 1'b0;
        bus0.wr_en1   = 1'b0;
        bus0.wr_addr0 = '0;
        bus0.wr_addr1 = '0;
        bus0.wr_data0 = '0;
        bus0.wr_data1 = '0;
        bus0.wr_rel0  = 1'b0;
        bus0.wr_rel1  = 1'b0;
        bus0.rsv_en   = 1'b0;
        bus0.rsv_addr = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic wr(int port, int addr, logic [DW-1:0] data, logic rel);
        if (port == 0) begin
            bus0.wr_en0   = 1'b1;
            bus0.wr_addr0 = AW'(addr);
            bus0.wr_data0 = data;
            bus0.wr_rel0  = rel;
        end else begin
            bus0.wr_en1   = 1'b1;
            bus0.wr_addr1 = AW'(addr);
            bus0.wr_data1 = data;
            bus0.wr_rel1  = rel;
        end
    endtask

    task automatic rsv(int addr);
        bus0.rsv_en   = 1'b1;
        bus0.rsv_addr = AW'(addr);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        bus0.rd_addr0 = '0;
        bus0.rd_addr1 = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Reset then read every address.
        for (int a = 0; a < 8; a++) begin
            bus0.rd_addr0 = AW'(a);
            bus0.rd_addr1 = AW'(7 - a);
            both(K_RD0, 0, 16'h0000, "rst_rd0");
            both(K_RD1, 0, 16'h0000, "rst_rd1");
            both(K_BSY0, 0, 16'h0000, "rst_busy0");
            both(K_BSY1, 0, 16'h0000, "rst_busy1");
            both(K_PEND, a, 16'h0000, "rst_pend");
            if (a == 0) both(K_ERR, 0, 16'h0000, "rst_err");
            tick();
        end

        // Dual-write conflict on r3: port 1 wins, also for the bypass path.
        wr(0, 3, 16'h1111, 1'b0);
        wr(1, 3, 16'h2222, 1'b0);
        bus0.rd_addr0 = 3'd3;
        push(K_RD0, 0, 0, 16'h0000, "dual_pre_nobyp");
        push(K_RD0, 1, 0, 16'h2222, "dual_pre_byp");
        tick();
        both(K_RD0, 0, 16'h2222, "dual_wr_r3");
        wr(0, 5, 16'hABCD, 1'b0);
        bus0.rd_addr1 = 3'd5;
        push(K_RD1, 0, 0, 16'h0000, "wr5_pre_nobyp");
        push(K_RD1, 1, 0, 16'hABCD, "wr5_pre_byp_p0");
        tick();
        bus0.rd_addr0 = 3'd5;
        both(K_RD0, 0, 16'hABCD, "wr5_post");
        both(K_RD1, 0, 16'hABCD, "wr5_post_rd1");
        tick();

        // Same-cycle bypass on read port 1.
        wr(1, 2, 16'h5A5A, 1'b0);
        bus0.rd_addr1 = 3'd2;
        push(K_RD1, 0, 0, 16'h0000, "byp_off_old");
        push(K_RD1, 1, 0, 16'h5A5A, "byp_on_same");
        tick();
        both(K_RD1, 0, 16'h5A5A, "byp_post");
        tick();

        // Reserve r4 to saturation, then overflow.
        bus0.rd_addr0 = 3'd4;
        rsv(4);
        both(K_BSY0, 0, 16'h0000, "busy_not_bypassed");
        tick();
        both(K_BSY0, 0, 16'h0001, "rsv1_busy");
        both(K_PEND, 4, 16'h0001, "rsv1_pend");
        rsv(4);
        tick();
        rsv(4);
        tick();
        both(K_PEND, 4, 16'h0003, "rsv3_pend");
        both(K_ERR, 0, 16'h0000, "rsv3_err");
        rsv(4);
        tick();
        both(K_PEND, 4, 16'h0003, "ovf_pend");
        both(K_ERR, 0, 16'h0001, "ovf_err");
        both(K_BSY0, 0, 16'h0001, "ovf_busy");

        // Three releasing writes to r4, alternating ports.
        for (int k = 0; k < 3; k++) begin
            wr(k % 2, 4, DW'(16'h0400 + k), 1'b1);
            tick();
            both(K_PEND, 4, DW'(2 - k), "rel_pend");
            both(K_BSY0, 0, (k < 2) ? 16'h0001 : 16'h0000, "rel_busy");
        end
        both(K_RD0, 0, 16'h0402, "rel_data");
        tick();

        // Reserve and release r6 on the same edge.
        rsv(6);
        tick();
        both(K_PEND, 6, 16'h0001, "r6_pend1");
        rsv(6);
        wr(0, 6, 16'h0606, 1'b1);
        tick();
        bus0.rd_addr1 = 3'd6;
        both(K_PEND, 6, 16'h0001, "rsvrel_pend");
        both(K_BSY1, 0, 16'h0001, "rsvrel_busy");
        both(K_RD1, 0, 16'h0606, "rsvrel_data");
        tick();

        // Reset mid-stream drops the write and reserve on the reset edge.
        rsv(1);
        tick();
        rsv(1);
        tick();
        both(K_PEND, 1, 16'h0002, "r1_pend2");
        both(K_ERR, 0, 16'h0001, "pre_rst_err");
        rst = 1'b1;
        wr(0, 1, 16'hFFFF, 1'b0);
        rsv(1);
        tick();
        rst = 1'b0;
        bus0.rd_addr0 = 3'd1;
        bus0.rd_addr1 = 3'd3;
        both(K_RD0, 0, 16'h0000, "mid_rst_r1");
        both(K_RD1, 0, 16'h0000, "mid_rst_r3");
        both(K_BSY0, 0, 16'h0000, "mid_rst_busy");
        both(K_PEND, 1, 16'h0000, "mid_rst_pend");
        both(K_ERR, 0, 16'h0000, "mid_rst_err");
        tick();

        // Release with nothing pending: underflow clamps at 0 and sets err.
        wr(1, 0, 16'h1234, 1'b1);
        tick();
        bus0.rd_addr0 = 3'd0;
        both(K_ERR, 0, 16'h0001, "unf_err");
        both(K_PEND, 0, 16'h0000, "unf_pend");
        both(K_RD0, 0, 16'h1234, "unf_data");
        tick();
        tick();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
